// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: registers ALU/link results for write-back, and
// waits on the data cache for loads, then extracts and extends the loaded
// byte, halfword or word. Flags misaligned loads and counts miss-wait cycles.
module mem_wb_stage #(
   parameter int unsigned bit_size = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_RegWrite,
   input  logic                in_Jal,
   input  logic [2:0]          in_load_type,
   input  logic [1:0]          in_addr_lo,
   input  logic [4:0]          in_Write_addr,
   input  logic [bit_size-1:0] in_ALU_result,
   input  logic [bit_size-1:0] in_PC_plus8,
   input  logic [bit_size-1:0] DM_rdata,
   input  logic                DM_rvalid,
   output logic                RegWrite,
   output logic [4:0]          Write_addr,
   output logic [bit_size-1:0] Write_data,
   output logic                misalign_err,
   output logic [15:0]         stall_cnt
);

   typedef enum logic {IDLE, WAIT_MEM} state_e;

   typedef enum logic [2:0] {
      LD_NONE = 3'b000,
      LD_LB   = 3'b001,
      LD_LBU  = 3'b010,
      LD_LH   = 3'b011,
      LD_LHU  = 3'b100,
      LD_LW   = 3'b101
   } load_e;

   state_e              state, state_n;
   load_e               ld_type, ld_type_n;
   logic [1:0]          ld_lo, ld_lo_n;
   logic [4:0]          ld_addr, ld_addr_n;
   logic                ld_we, ld_we_n;
   logic                we_n, mis_n;
   logic [4:0]          waddr_n;
   logic [bit_size-1:0] wdata_n;
   logic [15:0]         stall_n;
   logic [7:0]          sel_byte;
   logic [15:0]         sel_half;
   logic [bit_size-1:0] load_val;
   logic                is_load, aligned;

   assign in_ready = (state == IDLE);

   // Decode the incoming load kind and its alignment requirement
   always_comb begin
      is_load = 1'b1;
      aligned = 1'b1;
      case (in_load_type)
         LD_LB, LD_LBU: aligned = 1'b1;
         LD_LH, LD_LHU: aligned = ~in_addr_lo[0];
         LD_LW:         aligned = (in_addr_lo == 2'b00);
         default:       is_load = 1'b0;
      endcase
   end

   // Little-endian lane selection and sign/zero extension of the returned word
   always_comb begin
      sel_byte = DM_rdata[{ld_lo, 3'b000} +: 8];
      sel_half = DM_rdata[{ld_lo[1], 4'b0000} +: 16];
      case (ld_type)
         LD_LB:   load_val = {{(bit_size-8){sel_byte[7]}}, sel_byte};
         LD_LBU:  load_val = {{(bit_size-8){1'b0}}, sel_byte};
         LD_LH:   load_val = {{(bit_size-16){sel_half[15]}}, sel_half};
         LD_LHU:  load_val = {{(bit_size-16){1'b0}}, sel_half};
         default: load_val = DM_rdata;
      endcase
   end

   // Next-state and next-output logic; write port holds when not writing
   always_comb begin
      state_n   = state;
      ld_type_n = ld_type;
      ld_lo_n   = ld_lo;
      ld_addr_n = ld_addr;
      ld_we_n   = ld_we;
      we_n      = 1'b0;
      mis_n     = 1'b0;
      waddr_n   = Write_addr;
      wdata_n   = Write_data;
      stall_n   = stall_cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (!is_load) begin
                  if (in_RegWrite && (in_Write_addr != 5'd0)) begin
                     we_n    = 1'b1;
                     waddr_n = in_Write_addr;
                     wdata_n = in_Jal ? in_PC_plus8 : in_ALU_result;
                  end
               end else if (aligned) begin
                  ld_type_n = load_e'(in_load_type);
                  ld_lo_n   = in_addr_lo;
                  ld_addr_n = in_Write_addr;
                  ld_we_n   = in_RegWrite;
                  state_n   = WAIT_MEM;
               end else begin
                  mis_n = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            if (DM_rvalid) begin
               state_n = IDLE;
               if (ld_we && (ld_addr != 5'd0)) begin
                  we_n    = 1'b1;
                  waddr_n = ld_addr;
                  wdata_n = load_val;
               end
            end else if (stall_cnt != 16'hFFFF) begin
               stall_n = stall_cnt + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ld_type      <= LD_NONE;
         ld_lo        <= '0;
         ld_addr      <= '0;
         ld_we        <= 1'b0;
         RegWrite     <= 1'b0;
         Write_addr   <= '0;
         Write_data   <= '0;
         misalign_err <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         state        <= state_n;
         ld_type      <= ld_type_n;
         ld_lo        <= ld_lo_n;
         ld_addr      <= ld_addr_n;
         ld_we        <= ld_we_n;
         RegWrite     <= we_n;
         Write_addr   <= waddr_n;
         Write_data   <= wdata_n;
         misalign_err <= mis_n;
         stall_cnt    <= stall_n;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected register
// writes into a queue, a negedge monitor pops and compares every RegWrite.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_RegWrite;
   logic        in_Jal;
   logic [2:0]  in_load_type;
   logic [1:0]  in_addr_lo;
   logic [4:0]  in_Write_addr;
   logic [31:0] in_ALU_result;
   logic [31:0] in_PC_plus8;
   logic [31:0] DM_rdata;
   logic        DM_rvalid;
   logic        RegWrite;
   logic [4:0]  Write_addr;
   logic [31:0] Write_data;
   logic        misalign_err;
   logic [15:0] stall_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [36:0] exp_q[$];
   logic [15:0] s0;

   always #5 clk = ~clk;

   mem_wb_stage #(.bit_size(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_RegWrite(in_RegWrite), .in_Jal(in_Jal), .in_load_type(in_load_type),
      .in_addr_lo(in_addr_lo), .in_Write_addr(in_Write_addr),
      .in_ALU_result(in_ALU_result), .in_PC_plus8(in_PC_plus8),
      .DM_rdata(DM_rdata), .DM_rvalid(DM_rvalid), .RegWrite(RegWrite),
      .Write_addr(Write_addr), .Write_data(Write_data),
      .misalign_err(misalign_err), .stall_cnt(stall_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected write
   always @(negedge clk) begin
      if (RegWrite === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                     Write_addr, Write_data);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({Write_addr, Write_data} !== e) begin
               errors++;
               $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                        Write_addr, Write_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for one accept edge, then drop in_valid
   task automatic issue(input logic [2:0] lt, input logic we, input logic jal,
                        input logic [1:0] lo, input logic [4:0] addr,
                        input logic [31:0] alu, input logic [31:0] pc);
      in_valid      = 1'b1;
      in_load_type  = lt;
      in_RegWrite   = we;
      in_Jal        = jal;
      in_addr_lo    = lo;
      in_Write_addr = addr;
      in_ALU_result = alu;
      in_PC_plus8   = pc;
      step();
      in_valid = 1'b0;
   endtask

   // Return load data after 'wait_cycles' miss cycles
   task automatic respond(input int unsigned wait_cycles, input logic [31:0] data);
      repeat (wait_cycles) begin
         check("in_ready_wait", {31'd0, in_ready}, 32'd0);
         step();
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd0);
      DM_rvalid = 1'b1;
      DM_rdata  = data;
      step();
      DM_rvalid = 1'b0;
      check("in_ready_after_load", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_RegWrite = 1'b0; in_Jal = 1'b0;
      in_load_type = 3'b000; in_addr_lo = 2'b00; in_Write_addr = 5'd0;
      in_ALU_result = '0; in_PC_plus8 = '0; DM_rdata = '0; DM_rvalid = 1'b0;
      step(); step();
      check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
      check("rst_Write_addr", {27'd0, Write_addr}, 32'd0);
      check("rst_Write_data", Write_data, 32'd0);
      check("rst_misalign", {31'd0, misalign_err}, 32'd0);
      check("rst_stall", {16'd0, stall_cnt}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      step();

      // ADD, then back-to-back: ADD, JAL, ADD to r0, non-writing op
      exp_q.push_back({5'd8, 32'h0000_1234});
      issue(3'b000, 1'b1, 1'b0, 2'b00, 5'd8, 32'h0000_1234, 32'h0);
      exp_q.push_back({5'd3, 32'hDEAD_BEEF});
      issue(3'b000, 1'b1, 1'b0, 2'b00, 5'd3, 32'hDEAD_BEEF, 32'h0);
      check("b2b_pulse", {31'd0, RegWrite}, 32'd1);
      exp_q.push_back({5'd31, 32'h0040_0010});
      issue(3'b000, 1'b1, 1'b1, 2'b00, 5'd31, 32'h1111_1111, 32'h0040_0010);
      check("b2b_pulse_jal", {31'd0, RegWrite}, 32'd1);
      issue(3'b000, 1'b1, 1'b0, 2'b00, 5'd0, 32'h5555_5555, 32'h0);
      check("r0_no_write", {31'd0, RegWrite}, 32'd0);
      issue(3'b000, 1'b0, 1'b0, 2'b00, 5'd7, 32'h7777_7777, 32'h0);
      check("nowe_no_write", {31'd0, RegWrite}, 32'd0);
      step();

      // DM_rvalid while idle must be ignored
      DM_rvalid = 1'b1; DM_rdata = 32'hFFFF_FFFF;
      step();
      DM_rvalid = 1'b0;

      // LB / LBU hits on byte 2 of 0x1280FF00
      exp_q.push_back({5'd5, 32'hFFFF_FF80});
      issue(3'b001, 1'b1, 1'b0, 2'b10, 5'd5, 32'h0, 32'h0);
      check("load_accept_no_write", {31'd0, RegWrite}, 32'd0);
      respond(0, 32'h1280_FF00);
      exp_q.push_back({5'd5, 32'h0000_0080});
      issue(3'b010, 1'b1, 1'b0, 2'b10, 5'd5, 32'h0, 32'h0);
      respond(0, 32'h1280_FF00);

      // LW miss: data arrives 4 cycles after accept, 3 stall cycles
      s0 = stall_cnt;
      exp_q.push_back({5'd9, 32'hCAFE_F00D});
      issue(3'b101, 1'b1, 1'b0, 2'b00, 5'd9, 32'h0, 32'h0);
      respond(3, 32'hCAFE_F00D);
      check("stall_cnt_delta", {16'd0, stall_cnt}, {16'd0, s0 + 16'd3});

      // Misaligned LH and LW
      issue(3'b011, 1'b1, 1'b0, 2'b01, 5'd4, 32'h0, 32'h0);
      check("lh_misalign", {31'd0, misalign_err}, 32'd1);
      check("lh_mis_ready", {31'd0, in_ready}, 32'd1);
      check("lh_mis_nowrite", {31'd0, RegWrite}, 32'd0);
      step();
      check("misalign_one_cycle", {31'd0, misalign_err}, 32'd0);
      issue(3'b101, 1'b1, 1'b0, 2'b10, 5'd4, 32'h0, 32'h0);
      check("lw_misalign", {31'd0, misalign_err}, 32'd1);

      // Halfword loads, and a load to r0 that must not write
      exp_q.push_back({5'd10, 32'hFFFF_8001});
      issue(3'b011, 1'b1, 1'b0, 2'b10, 5'd10, 32'h0, 32'h0);
      check("lh_aligned_no_err", {31'd0, misalign_err}, 32'd0);
      respond(1, 32'h8001_1234);
      exp_q.push_back({5'd11, 32'h0000_F234});
      issue(3'b100, 1'b1, 1'b0, 2'b00, 5'd11, 32'h0, 32'h0);
      respond(0, 32'h8001_F234);
      issue(3'b001, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
      respond(0, 32'h0000_0077);
      check("load_r0_no_write", {31'd0, RegWrite}, 32'd0);

      // Reset while waiting drops the pending load
      issue(3'b101, 1'b1, 1'b0, 2'b00, 5'd12, 32'h0, 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      DM_rvalid = 1'b1; DM_rdata = 32'hBAD0_BAD0;
      step();
      DM_rvalid = 1'b0;
      check("rst_wait_ready", {31'd0, in_ready}, 32'd1);
      check("rst_wait_stall", {16'd0, stall_cnt}, 32'd0);
      check("rst_wait_nowrite", {31'd0, RegWrite}, 32'd0);
      step(); step();

      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL provide parameter bit_size, default 32, meaning datapath width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock; all state changes on posedge clk
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM-stage instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_RegWrite  in  1  instruction writes a register
- in_Jal  in  1  write data is in_PC_plus8
- in_load_type  in  3  000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, others none
- in_addr_lo  in  2  load address bits [1:0]
- in_Write_addr  in  5  destination register
- in_ALU_result  in  bit_size  ALU result
- in_PC_plus8  in  bit_size  link address
- DM_rdata  in  bit_size  data-cache read word
- DM_rvalid  in  1  DM_rdata valid (1 cycle on hit, later on miss)
- RegWrite  out  1  register-file write enable
- Write_addr  out  5  register-file write address
- Write_data  out  bit_size  register-file write data
- misalign_err  out  1  one-cycle misaligned-load flag
- stall_cnt  out  16  saturating count of miss-wait cycles

Function
REQ-004 States SHALL be IDLE and WAIT_MEM; in_ready SHALL be 1 in IDLE, 0 in WAIT_MEM.
REQ-005 Accept SHALL mean in_valid=1 and in_ready=1 at a posedge; in_valid while in_ready=0 SHALL be ignored (upstream holds).
REQ-006 Accepted non-load (load_type none): at next posedge RegWrite=in_RegWrite and (in_Write_addr!=0), Write_addr=in_Write_addr, Write_data=in_Jal ? in_PC_plus8 : in_ALU_result; latency 1 cycle; state stays IDLE.
REQ-007 Accepted aligned load: latch Write_addr, load_type, addr_lo, RegWrite intent; go WAIT_MEM; RegWrite=0 next cycle.
REQ-008 Alignment: LW needs addr_lo=00; LH/LHU need addr_lo[0]=0; LB/LBU always aligned.
REQ-009 Accepted misaligned load: misalign_err=1 next cycle for exactly one cycle, RegWrite=0, state stays IDLE.
REQ-010 DM_rvalid SHALL be sampled only in WAIT_MEM, from the cycle after accept; DM_rvalid in IDLE ignored.
REQ-011 WAIT_MEM with DM_rvalid=1: next posedge RegWrite=latched intent and (addr!=0), Write_data=extracted load value, state IDLE.
REQ-012 Extraction little-endian: byte k = DM_rdata[8k+7:8k], k=addr_lo; halfword = DM_rdata[16h+15:16h], h=addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-013 Each WAIT_MEM cycle with DM_rvalid=0 SHALL increment stall_cnt, saturating at 16'hFFFF.
REQ-014 RegWrite SHALL be a one-cycle pulse per written instruction; Write_addr/Write_data hold last value when RegWrite=0.
REQ-015 Write_addr=0 SHALL never produce RegWrite=1.
REQ-016 Back-to-back accepts in IDLE SHALL give back-to-back RegWrite pulses, no bubble.
REQ-017 Load-complete cycle and next accept SHALL NOT overlap: in_ready rises the cycle after DM_rvalid.

Reset
REQ-018 rst=1 at posedge SHALL set state IDLE, RegWrite=0, Write_addr=0, Write_data=0, misalign_err=0, stall_cnt=0; rst takes priority over all inputs.
REQ-019 rst during WAIT_MEM SHALL drop the pending load; a later DM_rvalid SHALL NOT write.

Verification
REQ-020 ADD: in_valid, RegWrite=1, addr=8, ALU=0x1234 -> next cycle RegWrite=1, Write_addr=8, Write_data=0x00001234.
REQ-021 LB hit: addr_lo=10, addr=5, DM_rvalid next cycle with DM_rdata=0x1280FF00 -> following cycle Write_data=0xFFFFFF80, RegWrite=1; LBU same -> 0x00000080.
REQ-022 LW miss: DM_rvalid 4 cycles after accept -> in_ready=0 for 4 cycles, stall_cnt increments by 3, one RegWrite pulse with DM_rdata.
REQ-023 LH addr_lo=01 -> misalign_err one cycle, RegWrite=0, in_ready stays 1.
REQ-024 Jal to addr=31, PC_plus8=0x0040_0010 -> Write_data=0x00400010; ADD with addr=0 -> RegWrite stays 0.
REQ-025 rst asserted in WAIT_MEM, then DM_rvalid=1 -> no RegWrite, state IDLE, stall_cnt=0.
